// File: rtl/dual_rail_tx.sv
// dual_rail_tx: buffers synchronous words in a small FIFO and emits each one as a
// two-phase dual-rail transition on WIDTH lanes, one word per receiver ack toggle.
`timescale 1ns/1ps
module dual_rail_tx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [WIDTH-1:0]           tx_high,
    output logic [WIDTH-1:0]           tx_low,
    input  logic                       tx_ack,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       timeout_err,
    output logic                       proto_err
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int NSYNC = SYNC_STAGES - 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [NSYNC-1:0]  sync_r;
    logic              ack_seen_r;
    logic [TW-1:0]     tmo_cnt_r;
    logic [TW-1:0]     tmo_cnt_s;
    logic [WIDTH-1:0]  tx_high_r;
    logic [WIDTH-1:0]  tx_low_r;
    logic              timeout_err_r;
    logic              proto_err_r;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              ack_edge_s;
    logic              tmo_hit_s;
    logic              proto_hit_s;
    logic [WIDTH-1:0]  head_s;

    assign in_ready_s = (count_r < CW'(DEPTH));
    assign push_s     = in_valid && in_ready_s;
    assign head_s     = mem_r[rd_ptr_r];
    // ack_seen_r is always loaded from the synchronizer output, so it also acts as
    // the final synchronizer stage; a difference between the two marks a new phase.
    assign ack_edge_s = sync_r[NSYNC-1] ^ ack_seen_r;

    assign in_ready    = in_ready_s;
    assign count       = count_r;
    assign tx_high     = tx_high_r;
    assign tx_low      = tx_low_r;
    assign timeout_err = timeout_err_r;
    assign proto_err   = proto_err_r;
    assign busy        = (state_r == ST_WAIT) || (count_r != CW'(0));

    // Ack synchronizer chain and last-consumed ack phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r     <= {NSYNC{1'b0}};
            ack_seen_r <= 1'b0;
        end else begin
            sync_r[0] <= tx_ack;
            for (int i = 1; i < NSYNC; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            ack_seen_r <= sync_r[NSYNC-1];
        end
    end

    // Next-state, pop decision and timeout counting.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        tmo_cnt_s   = tmo_cnt_r;
        tmo_hit_s   = 1'b0;
        proto_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ack_edge_s) begin
                    proto_hit_s = 1'b1;
                end else if (count_r != CW'(0)) begin
                    pop_s     = 1'b1;
                    state_s   = ST_WAIT;
                    tmo_cnt_s = TW'(0);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ack_edge_s) begin
                    state_s = ST_IDLE;
                end else begin
                    if (tmo_cnt_r != TMO_LIMIT) begin
                        tmo_cnt_s = tmo_cnt_r + TW'(1);
                    end else begin
                        tmo_cnt_s = tmo_cnt_r;
                    end
                    if ((TIMEOUT != 32'sd0) && (tmo_cnt_s == TMO_LIMIT)) begin
                        tmo_hit_s = 1'b1;
                    end else begin
                        tmo_hit_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= TW'(0);
            timeout_err_r <= 1'b0;
            proto_err_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            tmo_cnt_r <= tmo_cnt_s;
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end
            if (proto_hit_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Rails: each lane flips exactly one wire per emitted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_high_r <= {WIDTH{1'b0}};
            tx_low_r  <= {WIDTH{1'b0}};
        end else if (pop_s) begin
            tx_high_r <= tx_high_r ^ head_s;
            tx_low_r  <= tx_low_r ^ ~head_s;
        end
    end

endmodule

// File: tb/tb_dual_rail_tx.sv
// Bench for dual_rail_tx: directed phases plus a randomized stream, checked against a
// word-queue / rail-phase reference model kept here.
`timescale 1ns/1ps
module tb_dual_rail_tx;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int S   = 2;
    localparam int TMO = 10;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] tx_high;
    logic [W-1:0] tx_low;
    logic         tx_ack;
    logic         busy;
    logic [2:0]   count;
    logic         timeout_err;
    logic         proto_err;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] m_high;
    logic [W-1:0] m_low;
    logic [W-1:0] exp_q [$];

    dual_rail_tx #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx_high(tx_high), .tx_low(tx_low), .tx_ack(tx_ack),
        .busy(busy), .count(count), .timeout_err(timeout_err), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic toggle_ack();
        tx_ack = ~tx_ack;
    endtask

    task automatic push_word(input string tag, input logic [W-1:0] w);
        bit done = 1'b0;
        int n    = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!done && n < 60) begin
            done = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (done) exp_q.push_back(w);
        chk({tag, "_accepted"}, 32'(done), 32'd1);
    endtask

    // Waits for the rails to leave the model phase, then checks the emitted word.
    task automatic wait_emit(input string tag, input int budget, output int lat);
        logic [W-1:0] w;
        logic [W-1:0] oh;
        logic [W-1:0] ol;
        bit           moved;
        lat   = 0;
        moved = (tx_high !== m_high) || (tx_low !== m_low);
        while (!moved && lat < budget) begin
            tick();
            lat++;
            moved = (tx_high !== m_high) || (tx_low !== m_low);
        end
        chk({tag, "_emitted"}, 32'(moved), 32'd1);
        if (moved) begin
            chk({tag, "_word_pending"}, 32'(exp_q.size() != 0), 32'd1);
            w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            oh = m_high;
            ol = m_low;
            m_high = m_high ^ w;
            m_low  = m_low ^ ~w;
            chk({tag, "_high"}, 32'(tx_high), 32'(m_high));
            chk({tag, "_low"}, 32'(tx_low), 32'(m_low));
            chk({tag, "_wires"}, 32'($countones(tx_high ^ oh) + $countones(tx_low ^ ol)), 32'(W));
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tx_ack   = 1'b0;
        m_high   = '0;
        m_low    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_high", 32'(tx_high), 32'd0);
        chk("rst_low", 32'(tx_low), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", 32'({timeout_err, proto_err}), 32'd0);

        // Single word, then the same word again returns every rail to 0
        push_word("sw1", 8'hA5);
        chk("sw1_count", 32'(count), 32'd1);
        chk("sw1_no_early", 32'(tx_high), 32'(m_high));
        wait_emit("sw1", 4, lat);
        chk("sw1_latency", 32'(lat), 32'd1);
        chk("sw1_high_lit", 32'(tx_high), 32'h0000_00A5);
        chk("sw1_low_lit", 32'(tx_low), 32'h0000_005A);
        chk("sw1_busy", 32'(busy), 32'd1);
        toggle_ack();
        tick();
        chk("sw1_wait_busy", 32'(busy), 32'd1);
        tick();
        chk("sw1_idle_busy", 32'(busy), 32'd0);
        push_word("sw2", 8'hA5);
        wait_emit("sw2", 4, lat);
        chk("sw2_high_lit", 32'(tx_high), 32'd0);
        chk("sw2_low_lit", 32'(tx_low), 32'd0);
        toggle_ack();
        repeat (S) tick();

        // Fill with ack held: one word in flight, four buffered
        for (int k = 0; k < 5; k++) push_word("fill", 8'($urandom));
        chk("fill_count", 32'(count), 32'(D));
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fill_blocked_count", 32'(count), 32'(D));
        wait_emit("fill_w0", 0, lat);
        for (int k = 1; k < 5; k++) begin
            toggle_ack();
            wait_emit("drain", 10, lat);
            chk("drain_latency", 32'(lat), 32'(S + 1));
            chk("drain_count", 32'(count), 32'(exp_q.size()));
        end
        toggle_ack();
        repeat (S) tick();
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_count_end", 32'(count), 32'd0);

        // Randomized stream across pointer wrap with random ack delays
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_word("wrap_push", 8'($urandom));
                end
            end
            begin
                int l2;
                for (int k = 0; k < 20; k++) begin
                    wait_emit("wrap", 300, l2);
                    repeat ($urandom_range(0, 5)) tick();
                    toggle_ack();
                end
            end
        join
        repeat (S) tick();
        chk("wrap_busy", 32'(busy), 32'd0);
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wrap_no_errs", 32'({timeout_err, proto_err}), 32'd0);

        // Timeout: withheld ack sets the sticky flag TMO cycles after emission
        push_word("tmo", 8'($urandom));
        wait_emit("tmo", 4, lat);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("tmo_set", 32'(timeout_err), 32'd1);
        chk("tmo_still_busy", 32'(busy), 32'd1);
        toggle_ack();
        repeat (S) tick();
        chk("tmo_done_busy", 32'(busy), 32'd0);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-operation with a word in flight and others buffered
        push_word("mid", 8'($urandom));
        wait_emit("mid", 4, lat);
        push_word("mid_q1", 8'($urandom));
        push_word("mid_q2", 8'($urandom));
        #3 reset = 1'b1;
        tx_ack = 1'b0;
        #1;
        chk("mid_rst_high", 32'(tx_high), 32'd0);
        chk("mid_rst_low", 32'(tx_low), 32'd0);
        chk("mid_rst_errs", 32'({timeout_err, proto_err}), 32'd0);
        m_high = '0;
        m_low  = '0;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_ready", 32'(in_ready), 32'd1);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("mid_discard", 32'({tx_high, tx_low}), 32'd0);

        // Protocol error: ack toggle with nothing outstanding
        toggle_ack();
        tick();
        chk("proto_early", 32'(proto_err), 32'd0);
        tick();
        chk("proto_set", 32'(proto_err), 32'd1);
        chk("proto_rails", 32'({tx_high, tx_low}), 32'd0);
        w = 8'($urandom);
        push_word("post_proto", w);
        wait_emit("post_proto", 4, lat);
        chk("post_proto_latency", 32'(lat), 32'd1);
        toggle_ack();
        repeat (S) tick();
        chk("post_proto_busy", 32'(busy), 32'd0);
        chk("proto_sticky", 32'(proto_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_rail_tx.md
# dual_rail_tx

Clocked-to-asynchronous bridge that emits parallel words onto WIDTH two-phase dual-rail lanes, `Dual = {high, low}`. For each word, exactly one wire per lane toggles: `high` for a 1 and `low` for a 0. The block buffers words from a synchronous valid/ready producer in a small FIFO. It sends one word at a time and waits for a two-phase acknowledge toggle from the downstream dual-rail logic before sending the next word. It is the transmitting end for the dual-rail gate network, turning synchronous data into the transition-encoded form those gates consume.

## Interface
- WIDTH, 8: number of dual-rail lanes (bits per word).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flops in the ack synchronizer; at least 2.
- TIMEOUT, 1023: cycles in WAIT_ACK before `timeout_err` is set; 0 disables the timeout.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a word on `in_data`.
- in_ready  out  1  FIFO can accept a word; equals `count < DEPTH`.
- in_data  in  WIDTH  word to transmit.
- tx_high  out  WIDTH  `high` rail of lane i; toggles when bit i is 1.
- tx_low  out  WIDTH  `low` rail of lane i; toggles when bit i is 0.
- tx_ack  in  1  two-phase acknowledge from the receiver; asynchronous; toggles once per word consumed.
- busy  out  1  high while in WAIT_ACK or while the FIFO is non-empty.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- timeout_err  out  1  sticky; an ack wait exceeded TIMEOUT.
- proto_err  out  1  sticky; an ack toggle was seen while no word was outstanding.

## Operation
- **Transfer:** a word is written when `in_valid && in_ready` at a rising edge. Wr/rd pointers are log2(DEPTH) bits and wrap naturally.
- **Full FIFO:** `in_ready` = 0, so no push can occur.
- **Simultaneous push and pop:** count is unchanged. A word pushed into an empty FIFO is not poppable until the following cycle.
- **Ack synchronizer:** `tx_ack` passes through SYNC_STAGES flops to give `ack_s`. Register `ack_seen` holds the last consumed phase. An ack edge is `ack_s != ack_seen`.
- **State IDLE:**
  - FIFO non-empty: pop the head and, for every lane i, toggle `tx_high[i]` if bit i is 1, else toggle `tx_low[i]`. All lanes toggle on the same edge. Clear the timeout counter and go to WAIT_ACK.
  - FIFO empty: stay in IDLE.
  - Ack edge in IDLE: set `ack_seen <= ack_s`, set `proto_err`, and emit nothing on that edge.
- **State WAIT_ACK:**
  - Ack edge: set `ack_seen <= ack_s` and go to IDLE.
  - Otherwise: increment the timeout counter (saturating). When it reaches TIMEOUT (and TIMEOUT ≠ 0), set `timeout_err` and keep waiting; never drop or resend the word.
- **Invariant:** in each emission, exactly WIDTH wires toggle in total, one per lane. `tx_high` and `tx_low` change only on an IDLE→WAIT_ACK edge.
- **Reset values:** `tx_high` = 0, `tx_low` = 0, FIFO empty, `count` = 0, `in_ready` = 1, `busy` = 0, synchronizer flops = 0, `ack_seen` = 0, both error flags = 0, state IDLE. The receiver's ack phase is also reset to 0.
- **Reset mid-operation:** the in-flight word and all FIFO contents are discarded. Rails return to 0 immediately (asynchronously).

## Timing
- A word accepted at edge T into an empty FIFO while IDLE toggles its rails at edge T+1.
- An ack toggle arriving before edge A is detected at edge A+SYNC_STAGES-1, which moves the FSM to IDLE. The next word's rails toggle at edge A+SYNC_STAGES.
- Minimum spacing between emissions is SYNC_STAGES+1 cycles (ack returned immediately).
- `in_ready` and `count` update on the edge after a push or pop. `busy` is registered-state combinational.
- The error flags assert on the edge that detects the condition and hold until reset.

## Test plan
- **Reset:** assert `reset` mid-cycle → `tx_high` = `tx_low` = 0 immediately; after release, `in_ready` = 1, `count` = 0, `busy` = 0.
- **Single word:** push 0xA5 → one edge later `tx_high` = 0xA5 and `tx_low` = 0x5A. Toggle `tx_ack` → FSM returns to IDLE after SYNC_STAGES edges. Push 0xA5 again → `tx_high` = 0x00 and `tx_low` = 0x00 (each wire toggled once more).
- **Fill and backpressure:** with ack held, push 5 words → `in_ready` drops after the FIFO holds 4 (`count` = 4). Toggle ack repeatedly → words emerge in order, with XOR deltas on the rails matching the data; `count` reaches 0.
- **Pointer wrap:** stream 20 random words with random ack delays → every emission toggles exactly 8 wires and the decoded sequence matches the input.
- **Timeout:** set TIMEOUT = 10, push one word, withhold ack → `timeout_err` sets 10 cycles after the emission. A later ack still completes the word; the flag stays 1.
- **Protocol error:** toggle `tx_ack` while IDLE with an empty FIFO → `proto_err` = 1 after SYNC_STAGES edges and no rail changes. A subsequent word still transfers normally.
